// File: rtl/sw_if_pkg.sv
// rtl/sw_if_pkg.sv - shared constants for the decoder-to-switch select/ack interface
// Purpose: state encodings, operation codes and delay limits shared by the
//          switch responders and the decoder's tx scheduler.
// Ports:   none (package).
package sw_if_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_WAIT = WAIT,
      S_ACK  = ACK
   } sw_state_t;

   localparam logic WR_OP = 1'b1;
   localparam logic RD_OP = 1'b0;

   localparam int ACK_DELAY_MAX = 15;
   localparam int CNT_W         = $clog2(ACK_DELAY_MAX + 1);

endpackage

// File: rtl/sw_reg_responder_if.sv
// rtl/sw_reg_responder_if.sv - select/ack bundle between decoder and one switch
// Purpose: groups the request (select, op, address, write data) and response
//          (ack, read data, error, busy, overrun) signals of one switch.
// Ports:   master = decoder side (drives request, observes response);
//          slave  = switch side (observes request, drives response).
interface sw_reg_responder_if #(
   parameter int W_WIDTH = 8
);
   logic               sel_in;
   logic               wr_rd_s_in;
   logic [W_WIDTH-1:0] addr_in;
   logic [W_WIDTH-1:0] wr_data_in;
   logic               ack_out;
   logic [W_WIDTH-1:0] rd_data_out;
   logic               err_out;
   logic               busy_out;
   logic               ovr_err_out;

   modport master (
      output sel_in, wr_rd_s_in, addr_in, wr_data_in,
      input  ack_out, rd_data_out, err_out, busy_out, ovr_err_out
   );

   modport slave (
      input  sel_in, wr_rd_s_in, addr_in, wr_data_in,
      output ack_out, rd_data_out, err_out, busy_out, ovr_err_out
   );
endinterface

// File: rtl/sw_reg_bank.sv
// rtl/sw_reg_bank.sv - REG_COUNT x W_WIDTH register bank, one write and one read port
// Purpose: local storage of a switch; synchronous reset clears every register.
// Ports:   clk, rst (sync, active-high); we/idx/data write port committing on
//          the rising edge; rd_data combinational read of register idx.
module sw_reg_bank #(
   parameter int W_WIDTH   = 8,
   parameter int REG_COUNT = 4,
   parameter int IDX_W     = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [IDX_W-1:0]   idx,
   input  logic [W_WIDTH-1:0] data,
   output logic [W_WIDTH-1:0] rd_data
);

   logic [W_WIDTH-1:0] regs [REG_COUNT];

   // Index compare loops keep non-power-of-two banks safe: an index past
   // the last register neither writes nor reads anything.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (idx == IDX_W'(i)) regs[i] <= data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (idx == IDX_W'(i)) rd_data = regs[i];
      end
   end

endmodule

// File: rtl/sw_reg_responder.sv
// rtl/sw_reg_responder.sv - switch-side select/ack responder with local register bank
// Purpose: captures one transaction per select, waits ACK_DELAY cycles, then
//          returns a one-cycle ack with read data / error and commits writes.
// Ports:   clk, rst (sync, active-high); bus (slave modport): sel_in,
//          wr_rd_s_in, addr_in, wr_data_in in; ack_out, rd_data_out, err_out,
//          busy_out, ovr_err_out out.
module sw_reg_responder
   import sw_if_pkg::*;
#(
   parameter int W_WIDTH   = 8,
   parameter int REG_COUNT = 4,
   parameter int BASE_ADDR = 0,
   parameter int ACK_DELAY = 2
) (
   input  logic               clk,
   input  logic               rst,
   sw_reg_responder_if.slave  bus
);

   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [W_WIDTH-1:0] BASE = W_WIDTH'(BASE_ADDR);

   sw_state_t          state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_wr;
   logic [W_WIDTH-1:0] lat_addr;
   logic [W_WIDTH-1:0] lat_data;
   logic               ack_q;
   logic               busy_q;
   logic               ovr_q;

   logic [W_WIDTH-1:0] offset;
   logic               hit;
   logic [IDX_W-1:0]   idx;
   logic               we;
   logic [W_WIDTH-1:0] bank_rd;

   // The ACK state launches the registered ack pulse, so the ack is visible
   // in the cycle after ACK while the FSM is already back in IDLE. A select
   // sampled during that visible ack cycle is a legal back-to-back capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         lat_wr   <= RD_OP;
         lat_addr <= '0;
         lat_data <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.sel_in) begin
                  lat_wr   <= bus.wr_rd_s_in;
                  lat_addr <= bus.addr_in;
                  lat_data <= bus.wr_data_in;
                  busy_q   <= 1'b1;
                  if (ACK_DELAY == 0) begin
                     state <= S_ACK;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_W'(ACK_DELAY - 1);
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bus.sel_in) ovr_q <= 1'b1;
               busy_q <= 1'b1;
               if (cnt == '0) state <= S_ACK;
               else           cnt   <= cnt - 1'b1;
            end
            S_ACK: begin
               if (bus.sel_in) ovr_q <= 1'b1;
               busy_q <= 1'b1;
               ack_q  <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The subtraction only matters when addr >= BASE, so it never wraps for
   // a hit; the extra bit lets REG_COUNT reach 2^W_WIDTH.
   assign offset = lat_addr - BASE;
   assign hit    = (lat_addr >= BASE) &&
                   ({1'b0, offset} < (W_WIDTH + 1)'(REG_COUNT));
   assign idx    = offset[IDX_W-1:0];
   assign we     = ack_q && (lat_wr == WR_OP) && hit;

   sw_reg_bank #(
      .W_WIDTH   (W_WIDTH),
      .REG_COUNT (REG_COUNT),
      .IDX_W     (IDX_W)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .idx     (idx),
      .data    (lat_data),
      .rd_data (bank_rd)
   );

   // Zero outside a read-hit ack so several switches can be OR-ed together.
   assign bus.rd_data_out = (ack_q && (lat_wr == RD_OP) && hit) ? bank_rd : '0;
   assign bus.ack_out     = ack_q;
   assign bus.err_out     = ack_q && !hit;
   assign bus.busy_out    = busy_q;
   assign bus.ovr_err_out = ovr_q;

endmodule

// File: doc/sw_reg_responder.md
Name: sw_reg_responder

Overview:
Switch-side responder for the decoder-to-switch select/ack interface. It captures one transaction per select pulse: address, write/read flag and write data. It performs the access on a local register bank after a fixed, parameterised delay, then returns a one-cycle ack with read data. One instance sits behind each sel_en bit driven by the address decoder. Its ack and rd_data feed the decoder's receive path.

Parameters:
W_WIDTH, 8, width of address, write data and read data.
REG_COUNT, 4, number of W_WIDTH registers in the bank (1..2^W_WIDTH).
BASE_ADDR, 0, first address owned by this switch.
ACK_DELAY, 2, idle cycles between capture and ack (0..15).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
sel_in  in  1  select from decoder (one sel_en bit); request when high.
wr_rd_s_in  in  1  1 = write, 0 = read; sampled with sel_in.
addr_in  in  W_WIDTH  absolute address; sampled with sel_in.
wr_data_in  in  W_WIDTH  write data; sampled with sel_in.
ack_out  out  1  one-cycle completion pulse.
rd_data_out  out  W_WIDTH  read data, valid only while ack_out=1, else 0.
err_out  out  1  high with ack_out when the address is outside the bank.
busy_out  out  1  high from the cycle after capture through the ack cycle.
ovr_err_out  out  1  sticky flag: sel_in seen while busy; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, delay counter=0, all registers=0.
- Reset outputs: ack_out, err_out, busy_out, ovr_err_out = 0; rd_data_out = 0.
- Reset mid-transaction aborts it: no ack is issued and no write commits.
- States: IDLE, WAIT, ACK.
- IDLE: if sel_in=1 at edge T, latch wr_rd_s_in, addr_in and wr_data_in.
  - If ACK_DELAY=0, go to ACK.
  - Otherwise go to WAIT with cnt=ACK_DELAY-1.
  - sel_in=0: stay in IDLE.
- WAIT: when cnt=0, go to ACK; otherwise cnt decrements each cycle.
- ACK: ack_out=1 for exactly this one cycle, then go to IDLE.
- Latency: a select captured at edge T gives ack_out high in the cycle following edge T+1+ACK_DELAY, i.e. the ack is sampled by the decoder at edge T+2+ACK_DELAY.
- busy_out = (state != IDLE), registered.
- Address decode on the latched address:
  - hit = (addr >= BASE_ADDR) && (addr - BASE_ADDR < REG_COUNT).
  - Subtraction is unsigned at W_WIDTH and is evaluated only when addr >= BASE_ADDR, so it never wraps.
  - Register index = addr - BASE_ADDR, truncated to clog2(REG_COUNT) bits (minimum 1 bit).
- Write: commits at the clock edge ending the ACK cycle, only if hit. rd_data_out=0 during the write ack.
- Read: in the ACK cycle, rd_data_out = reg[index] if hit, else 0. rd_data_out is combinational from the latched index and the registers.
- err_out = ACK & ~hit, for both reads and writes. A miss never modifies registers.
- rd_data_out is 0 outside ACK so that several instances can be OR-ed onto the shared rd_data bus.
- sel_in=1 in WAIT or ACK: the request is ignored, ovr_err_out is set to 1 and the current transaction is unaffected.
- Back-to-back: a select in the cycle right after ACK (state IDLE) is accepted. Minimum spacing between accepted selects is ACK_DELAY+2 cycles.
- Read-after-write to the same register returns the new value.
- sel_in held high continuously: one transaction per IDLE visit. Each re-capture happens in IDLE and is legal; each busy cycle with sel_in high sets ovr_err_out.

Decomposition:
- Shared package sw_if_pkg:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - WR_OP=1'b1 and RD_OP=1'b0, also used by the decoder's tx scheduler;
  - ACK_DELAY maximum constant.
- One sub-module, sw_reg_bank: REG_COUNT x W_WIDTH registers with synchronous rst, one write port (we, idx, data) and one combinational read port.
- The FSM, counter, address decode and output gating stay in sw_reg_responder.

Test Plan:
- Defaults, rst then write: sel=1, wr=1, addr=8'h02, data=8'hA5 at edge 0 -> ack_out=1 for exactly one cycle, sampled at edge 4 (T+2+ACK_DELAY), err_out=0, rd_data_out=0. A read of 8'h02 then returns 8'hA5 with its ack.
- Out-of-range, BASE_ADDR=8'h10, REG_COUNT=4:
  - read 8'h14 -> ack with err_out=1, rd_data_out=0;
  - write 8'h0F, data 8'h33 -> ack with err_out=1; reading all 4 registers afterwards returns 0.
- ACK_DELAY=0, select at edge T -> ack sampled at edge T+2. A second select at T+2 (IDLE) is accepted and acks at T+4. ovr_err_out stays 0.
- Select pulse while busy (edge T+1 after capture at T, ACK_DELAY=2) -> original ack still at T+4, the second request is dropped, ovr_err_out=1 and stays 1 until rst.
- Reset mid-operation: write 8'h01, data 8'h5A captured, rst=1 during WAIT -> no ack, busy_out=0 next cycle, and a subsequent read of 8'h01 returns 8'h00.
- Two instances OR-ed, read to instance A only -> the shared bus equals A's data in A's ack cycle, and B's rd_data_out=0 throughout.
